// File: rtl/vproc_mac_pipe.sv
// Pipelined multiply-accumulate (zero / acc_i / running acc, add or sub); VPROC_MAC_SAT_EN enables signed clamping.
// Latency STAGES cycles (1..3), one op per cycle.
// Global stall: every stage and acc_q hold while out_valid_o && !out_ready_i; in_ready_o mirrors that.
module vproc_mac_pipe #(
    parameter int unsigned  OP_W   = 16,
    parameter int unsigned  STAGES = 2,
    localparam int unsigned RES_W  = 2*OP_W+1
) (
    input  logic             clk_i,
    input  logic             async_rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  op1_i,
    input  logic [OP_W-1:0]  op2_i,
    input  logic             op1_signed_i,
    input  logic             op2_signed_i,
    input  logic [RES_W-1:0] acc_i,
    input  logic [1:0]       acc_mode_i,
    input  logic             acc_sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [RES_W-1:0] res_o,
    output logic             sat_o
);

    typedef struct packed {
        logic             vld;
        logic [OP_W:0]    op1;
        logic [OP_W:0]    op2;
        logic [RES_W-1:0] acc;
        logic [1:0]       mode;
        logic             sub;
    } stg_a_t;

    typedef struct packed {
        logic             vld;
        logic [RES_W-1:0] prod;
        logic [RES_W-1:0] acc;
        logic [1:0]       mode;
        logic             sub;
    } stg_b_t;

    logic             advance;
    stg_a_t           a_d, a_s;
    stg_b_t           b_d, b_s;
    logic [RES_W-1:0] op1_x, op2_x;
    logic [RES_W-1:0] acc_sel, res_c;
    logic             sat_c;
    logic             out_valid_d, out_valid_q;
    logic [RES_W-1:0] res_d, res_q;
    logic             sat_d, sat_q;
    logic [RES_W-1:0] acc_d, acc_q;

    assign advance    = !out_valid_q || out_ready_i;
    assign in_ready_o = advance;

    always_comb begin
        a_d      = '0;
        a_d.vld  = in_valid_i;
        a_d.op1  = {op1_signed_i & op1_i[OP_W-1], op1_i};
        a_d.op2  = {op2_signed_i & op2_i[OP_W-1], op2_i};
        a_d.acc  = acc_i;
        a_d.mode = acc_mode_i;
        a_d.sub  = acc_sub_i;
    end

    if (STAGES == 3) begin : g_stage_a
        stg_a_t a_q;
        always_ff @(posedge clk_i or negedge async_rst_ni) begin
            if (!async_rst_ni) begin
                a_q <= '0;
            end else if (flush_i) begin
                a_q.vld <= 1'b0;
            end else if (advance) begin
                a_q <= a_d;
            end
        end
        assign a_s = a_q;
    end else begin : g_no_stage_a
        assign a_s = a_d;
    end

    // Product of the sign-extended operands fits in RES_W bits, so a
    // RES_W-wide modular multiply yields the exact signed product.
    always_comb begin
        op1_x    = {{(RES_W-OP_W-1){a_s.op1[OP_W]}}, a_s.op1};
        op2_x    = {{(RES_W-OP_W-1){a_s.op2[OP_W]}}, a_s.op2};
        b_d      = '0;
        b_d.vld  = a_s.vld;
        b_d.prod = op1_x * op2_x;
        b_d.acc  = a_s.acc;
        b_d.mode = a_s.mode;
        b_d.sub  = a_s.sub;
    end

    if (STAGES >= 2) begin : g_stage_b
        stg_b_t b_q;
        always_ff @(posedge clk_i or negedge async_rst_ni) begin
            if (!async_rst_ni) begin
                b_q <= '0;
            end else if (flush_i) begin
                b_q.vld <= 1'b0;
            end else if (advance) begin
                b_q <= b_d;
            end
        end
        assign b_s = b_q;
    end else begin : g_no_stage_b
        assign b_s = b_d;
    end

`ifdef VPROC_MAC_SAT_EN
    logic [RES_W:0] sum_x;
`endif

    always_comb begin
        case (b_s.mode)
            2'b01:   acc_sel = b_s.acc;
            2'b10:   acc_sel = acc_q;
            default: acc_sel = '0;
        endcase
`ifdef VPROC_MAC_SAT_EN
        sum_x = b_s.sub ? ({acc_sel[RES_W-1], acc_sel} - {b_s.prod[RES_W-1], b_s.prod})
                        : ({acc_sel[RES_W-1], acc_sel} + {b_s.prod[RES_W-1], b_s.prod});
        sat_c = sum_x[RES_W] != sum_x[RES_W-1];
        if (sat_c) begin
            res_c = sum_x[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
        end else begin
            res_c = sum_x[RES_W-1:0];
        end
`else
        sat_c = 1'b0;
        res_c = b_s.sub ? (acc_sel - b_s.prod) : (acc_sel + b_s.prod);
`endif
    end

    // acc_q follows every result written, so mode 10 always chains off the previous op.
    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        sat_d       = sat_q;
        acc_d       = acc_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
        end else if (advance) begin
            out_valid_d = b_s.vld;
            if (b_s.vld) begin
                res_d = res_c;
                sat_d = sat_c;
                acc_d = res_c;
            end
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            sat_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            sat_q       <= sat_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign res_o       = res_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_vproc_mac_pipe.sv
// Bench for vproc_mac_pipe: a STAGES=2 and a STAGES=3 instance share operand buses,
// each with its own valid/ready and result scoreboard.
module tb_vproc_mac_pipe;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] op1 = '0, op2 = '0;
    logic        s1 = 1'b0, s2 = 1'b0;
    logic [32:0] acc = '0;
    logic [1:0]  mode = '0;
    logic        sub = 1'b0;

    logic        iv2 = 1'b0, ir2, ov2, ordy2 = 1'b1, sat2;
    logic [32:0] res2;
    logic        iv3 = 1'b0, ir3, ov3, ordy3 = 1'b1, sat3;
    logic [32:0] res3;

    typedef struct {
        logic [32:0] res;
        logic        sat;
        int          pres;
        bit          lat;
    } exp_t;

    exp_t        sb2[$];
    exp_t        sb3[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [32:0] macc2 = '0, macc3 = '0;

`ifdef VPROC_MAC_SAT_EN
    localparam logic [32:0] SAT_RES  = 33'h0_FFFF_FFFF;
    localparam logic        SAT_FLAG = 1'b1;
`else
    localparam logic [32:0] SAT_RES  = 33'h1_0000_0000;
    localparam logic        SAT_FLAG = 1'b0;
`endif

    vproc_mac_pipe #(.OP_W(16), .STAGES(2)) u_dut2 (
        .clk_i(clk), .async_rst_ni(arst_n), .flush_i(flush),
        .in_valid_i(iv2), .in_ready_o(ir2),
        .op1_i(op1), .op2_i(op2), .op1_signed_i(s1), .op2_signed_i(s2),
        .acc_i(acc), .acc_mode_i(mode), .acc_sub_i(sub),
        .out_valid_o(ov2), .out_ready_i(ordy2), .res_o(res2), .sat_o(sat2)
    );

    vproc_mac_pipe #(.OP_W(16), .STAGES(3)) u_dut3 (
        .clk_i(clk), .async_rst_ni(arst_n), .flush_i(flush),
        .in_valid_i(iv3), .in_ready_o(ir3),
        .op1_i(op1), .op2_i(op2), .op1_signed_i(s1), .op2_signed_i(s2),
        .acc_i(acc), .acc_mode_i(mode), .acc_sub_i(sub),
        .out_valid_o(ov3), .out_ready_i(ordy3), .res_o(res3), .sat_o(sat3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers, independent of bit-level tricks.
    function automatic logic [33:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sa, input logic sbf,
                                          input logic [32:0] ac, input logic [1:0] md,
                                          input logic sb_, input logic [32:0] aq);
        longint      x, y, av, s;
        logic [63:0] sv;
        logic        st;
        st = 1'b0;
        x  = sa  ? longint'($signed(a)) : longint'({48'd0, a});
        y  = sbf ? longint'($signed(b)) : longint'({48'd0, b});
        if (md == 2'b01)      av = longint'($signed(ac));
        else if (md == 2'b10) av = longint'($signed(aq));
        else                  av = 0;
        s = sb_ ? (av - x*y) : (av + x*y);
`ifdef VPROC_MAC_SAT_EN
        if (s > 64'sh0_FFFF_FFFF) begin
            s  = 64'sh0_FFFF_FFFF;
            st = 1'b1;
        end else if (s < -64'sh1_0000_0000) begin
            s  = -64'sh1_0000_0000;
            st = 1'b1;
        end
`endif
        sv = s;
        return {st, sv[32:0]};
    endfunction

    task automatic send(input bit u3, input logic [15:0] a, input logic [15:0] b,
                        input logic sa, input logic sbf, input logic [32:0] ac,
                        input logic [1:0] md, input logic sb_,
                        input logic [32:0] er, input logic es, input bit lat);
        bit ok;
        ok   = 1'b0;
        op1  = a;
        op2  = b;
        s1   = sa;
        s2   = sbf;
        acc  = ac;
        mode = md;
        sub  = sb_;
        if (u3) iv3 = 1'b1;
        else    iv2 = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = u3 ? ir3 : ir2;
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL accept_timeout: in_ready observed 0 expected 1");
        end
        if (ok) begin
            if (u3) begin
                sb3.push_back('{er, es, cyc, lat});
                macc3 = er;
            end else begin
                sb2.push_back('{er, es, cyc, lat});
                macc2 = er;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (ov2 && ordy2) begin
            checks++;
            assert (sb2.size() != 0) else begin
                errors++;
                $error("FAIL u2_spurious: observed res %0h expected no output", res2);
            end
            if (sb2.size() != 0) begin
                e = sb2.pop_front();
                chk("u2_res", res2, e.res);
                chk("u2_sat", sat2, e.sat);
                if (e.lat) chk("u2_latency", cyc - e.pres, 2);
            end
        end
        if (ov3 && ordy3) begin
            checks++;
            assert (sb3.size() != 0) else begin
                errors++;
                $error("FAIL u3_spurious: observed res %0h expected no output", res3);
            end
            if (sb3.size() != 0) begin
                e = sb3.pop_front();
                chk("u3_res", res3, e.res);
                chk("u3_sat", sat3, e.sat);
                if (e.lat) chk("u3_latency", cyc - e.pres, 3);
            end
        end
    end

    initial begin
        int          cnt;
        logic [33:0] m;
        logic [15:0] ra, rb;
        logic        rsa, rsb, rsub;
        logic [1:0]  rmd;
        logic [32:0] racc;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov2", ov2, 0);
        chk("rst_res2", res2, 0);
        chk("rst_sat2", sat2, 0);
        chk("rst_ir2", ir2, 1);
        chk("rst_ov3", ov3, 0);
        chk("rst_ir3", ir3, 1);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors on the STAGES=2 instance
        send(0, 16'hFFFD, 16'd7, 1, 1, 33'd0, 2'b00, 0, 33'h1_FFFF_FFEB, 0, 1);
        send(0, 16'hFFFF, 16'hFFFF, 0, 0, 33'd0, 2'b00, 0, 33'h0_FFFE_0001, 0, 1);
        send(0, 16'hFFFF, 16'hFFFF, 1, 1, 33'd0, 2'b00, 0, 33'd1, 0, 1);
        send(0, 16'd2, 16'd3, 0, 0, 33'd0, 2'b00, 0, 33'd6, 0, 1);
        send(0, 16'd4, 16'd5, 0, 0, 33'd0, 2'b10, 0, 33'd26, 0, 1);
        send(0, 16'd1, 16'd6, 0, 0, 33'd0, 2'b10, 1, 33'd20, 0, 1);
        send(0, 16'd3, 16'd4, 0, 0, 33'd100, 2'b01, 1, 33'd88, 0, 1);
        send(0, 16'd2, 16'd2, 0, 0, 33'h1_2345_6789, 2'b11, 0, 33'd4, 0, 1);
        send(0, 16'd1, 16'd1, 1, 1, 33'h0_FFFF_FFFF, 2'b01, 0, SAT_RES, SAT_FLAG, 1);
        iv2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Random ops against the model with random output backpressure
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    ra   = 16'($urandom());
                    rb   = 16'($urandom());
                    rsa  = 1'($urandom_range(0, 1));
                    rsb  = 1'($urandom_range(0, 1));
                    rmd  = 2'($urandom_range(0, 3));
                    rsub = 1'($urandom_range(0, 1));
                    racc = {1'($urandom_range(0, 1)), 32'($urandom())};
                    m    = model(ra, rb, rsa, rsb, racc, rmd, rsub, macc2);
                    send(0, ra, rb, rsa, rsb, racc, rmd, rsub, m[32:0], m[33], 0);
                end
                iv2 = 1'b0;
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    ordy2 = ($urandom_range(0, 3) != 0);
                end
                ordy2 = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("u2_drained", sb2.size(), 0);

        // Backpressure on the STAGES=3 instance
        ordy3 = 1'b0;
        cnt   = 0;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    send(1, 16'(k), 16'(k), 0, 0, 33'd0, 2'b00, 0, 33'(k*k), 0, 0);
                iv3 = 1'b0;
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (ov3) begin
                        cnt++;
                        chk("stall_in_ready", ir3, 0);
                        chk("stall_res_held", res3, 1);
                    end
                end
                @(posedge clk);
                #1;
                ordy3 = 1'b1;
            end
        join
        chk("stall_valid_cycles", cnt, 3);
        repeat (8) @(posedge clk);
        #1;
        chk("u3_drained", sb3.size(), 0);

        // Flush with two ops in flight and a third presented in the flush cycle
        send(1, 16'd7, 16'd7, 0, 0, 33'd0, 2'b00, 0, 33'd49, 0, 0);
        send(1, 16'd8, 16'd8, 0, 0, 33'd0, 2'b00, 0, 33'd64, 0, 0);
        flush = 1'b1;
        op1   = 16'd9;
        op2   = 16'd9;
        @(posedge clk);
        #1;
        flush = 1'b0;
        iv3   = 1'b0;
        sb3.delete();
        macc3 = '0;
        macc2 = '0;
        cnt   = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov3) cnt++;
        end
        chk("flush_no_output", cnt, 0);
        @(posedge clk);
        #1;
        send(1, 16'd2, 16'd3, 0, 0, 33'd0, 2'b10, 0, 33'd6, 0, 1);
        send(1, 16'd1, 16'd1, 0, 0, 33'd0, 2'b10, 1, 33'd5, 0, 1);
        iv3 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("u3_flush_drained", sb3.size(), 0);

        // Asynchronous reset mid-stream on the STAGES=2 instance
        send(0, 16'd3, 16'd3, 0, 0, 33'd0, 2'b00, 0, 33'd9, 0, 1);
        send(0, 16'd4, 16'd4, 0, 0, 33'd0, 2'b00, 0, 33'd16, 0, 1);
        send(0, 16'd5, 16'd5, 0, 0, 33'd0, 2'b00, 0, 33'd25, 0, 1);
        iv2 = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        chk("midrst_ov2", ov2, 0);
        chk("midrst_res2", res2, 0);
        chk("midrst_sat2", sat2, 0);
        chk("midrst_ir2", ir2, 1);
        chk("midrst_ov3", ov3, 0);
        sb2.delete();
        sb3.delete();
        macc2 = '0;
        macc3 = '0;
        repeat (2) @(posedge clk);
        #3;
        arst_n = 1'b1;
        cnt    = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov2) cnt++;
        end
        chk("postrst_no_stale", cnt, 0);
        @(posedge clk);
        #1;
        send(0, 16'd2, 16'd3, 0, 0, 33'd0, 2'b10, 0, 33'd6, 0, 1);
        iv2 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("u2_final_drained", sb2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
